// File: rtl/flag_reg_unit.sv
// flag_reg_unit
//   Holds the Z (zero), N (sign) and C (carry) status flags that feed the
//   jump controller, plus a small LIFO shadow stack that saves the flags on
//   interrupt entry and restores them on return-from-interrupt.
//
// Parameters
//   WIDTH : ALU result width in bits
//   DEPTH : number of shadow-stack entries (1..3)
//
// Ports
//   clk         : system clock, every state change on its rising edge
//   rst         : synchronous active-high reset
//   alu_res     : result of the current ALU operation
//   alu_cout    : carry/borrow out of the current ALU operation
//   upd_mask    : per-flag update enables, bit0=Z, bit1=N, bit2=C
//   setc, clrc  : force C to 1 / 0 (both high leaves C unchanged)
//   jmp_taken   : the jump controller took a jump this cycle
//   jmp_op      : condition code of that jump
//   int_save    : interrupt entry, push the flags
//   flg_restore : RTI, pop the flags
//   zero, sign, carry : registered flags
//   stk_cnt     : number of occupied shadow-stack entries
//   ovf_err, udf_err  : sticky push-overflow / pop-underflow errors
module flag_reg_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout,
  input  logic [2:0]       upd_mask,
  input  logic             setc,
  input  logic             clrc,
  input  logic             jmp_taken,
  input  logic [3:0]       jmp_op,
  input  logic             int_save,
  input  logic             flg_restore,
  output logic             zero,
  output logic             sign,
  output logic             carry,
  output logic [1:0]       stk_cnt,
  output logic             ovf_err,
  output logic             udf_err
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_EQUAL = 4'd2;
  localparam logic [3:0] OP_CARRY = 4'd8;

  logic       zero_q, sign_q, carry_q;
  logic       zero_d, sign_d, carry_d;
  logic [1:0] stkCnt_q;
  logic       ovfErr_q, udfErr_q;

  // Only the first DEPTH entries are ever written; the rest are pruned.
  logic [2:0] stack_q [4];

  logic       clearZ, clearC;
  logic       doPush, doPop, pushFull, popEmpty;
  logic [2:0] nextFlags;
  logic [2:0] topEntry;

  // Next flag values from the ALU, setc/clrc and jump consumption, in
  // priority order setc/clrc > upd_mask > jump consumption. Restore is
  // applied later because it must not feed into a same-cycle save.
  always_comb begin
    clearZ = jmp_taken && ((jmp_op == OP_ZERO) || (jmp_op == OP_EQUAL));
    clearC = jmp_taken && (jmp_op == OP_CARRY);

    zero_d = zero_q;
    if (upd_mask[0]) begin
      zero_d = (alu_res == '0);
    end else if (clearZ) begin
      zero_d = 1'b0;
    end

    sign_d = upd_mask[1] ? alu_res[WIDTH-1] : sign_q;

    carry_d = carry_q;
    if (setc && clrc) begin
      carry_d = carry_q;
    end else if (setc) begin
      carry_d = 1'b1;
    end else if (clrc) begin
      carry_d = 1'b0;
    end else if (upd_mask[2]) begin
      carry_d = alu_cout;
    end else if (clearC) begin
      carry_d = 1'b0;
    end

    nextFlags = {carry_d, sign_d, zero_d};
  end

  // Stack control: a restore always takes precedence over a save.
  always_comb begin
    doPop    = flg_restore && (stkCnt_q != 2'd0);
    popEmpty = flg_restore && (stkCnt_q == 2'd0);
    doPush   = int_save && !flg_restore && (stkCnt_q < DEPTH_C);
    pushFull = int_save && !flg_restore && (stkCnt_q >= DEPTH_C);
    topEntry = stack_q[stkCnt_q - 2'd1];
  end

  // Flag, occupancy and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
      stkCnt_q <= 2'd0;
      ovfErr_q <= 1'b0;
      udfErr_q <= 1'b0;
    end else begin
      if (doPop) begin
        {carry_q, sign_q, zero_q} <= topEntry;
        stkCnt_q <= stkCnt_q - 2'd1;
      end else begin
        {carry_q, sign_q, zero_q} <= nextFlags;
        if (doPush) begin
          stkCnt_q <= stkCnt_q + 2'd1;
        end
      end
      if (pushFull) begin
        ovfErr_q <= 1'b1;
      end
      if (popEmpty) begin
        udfErr_q <= 1'b1;
      end
    end
  end

  // Stack storage needs no reset: clearing the count discards its contents.
  always_ff @(posedge clk) begin
    if (!rst && doPush) begin
      stack_q[stkCnt_q] <= nextFlags;
    end
  end

  assign zero    = zero_q;
  assign sign    = sign_q;
  assign carry   = carry_q;
  assign stk_cnt = stkCnt_q;
  assign ovf_err = ovfErr_q;
  assign udf_err = udfErr_q;

endmodule
